// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. Storage is a RAM plus one head
// output register; the head register doubles as the RAM's synchronous read
// register. Provides exact occupancy, a "filled" threshold flag, synchronous
// flush and sticky overflow/underflow flags.
//
// Optional feature: define SYNC_FIFO_WATERMARK_EN to build the peak-level
// watermark on max_level; otherwise max_level is tied to zero.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush, overrides enqueue/dequeue
//   enqueue    write request; wdata is the write data
//   full       level == 2**SIZE_SCALE
//   dequeue    pop head entry
//   rdata      head entry, valid whenever empty == 0
//   empty      no head entry presented
//   filled     level > FILLED_THRESH
//   level      entries accepted and not yet dequeued (RAM + head)
//   overflow   sticky: enqueue attempted while full
//   underflow  sticky: dequeue attempted while empty
//   max_level  peak-level watermark
module sync_fifo_fwft #(
  parameter int SIZE_SCALE    = 10,
  parameter int WIDTH         = 8,
  parameter int FILLED_THRESH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  enqueue,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  full,
  input  logic                  dequeue,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic                  filled,
  output logic [SIZE_SCALE:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [SIZE_SCALE:0]   max_level
);

  localparam int DEPTH = 2 ** SIZE_SCALE;
  localparam int LW    = SIZE_SCALE + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L = LW'(FILLED_THRESH);

  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic [SIZE_SCALE-1:0] waddr_q, waddr_d;
  logic [SIZE_SCALE-1:0] raddr_q, raddr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         ram_cnt;
  logic                  head_valid_q, head_valid_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  full_q, filled_q;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  acc_enq, acc_deq, refill;

  always_comb begin
    acc_enq = enqueue & ~full_q & ~clr;
    acc_deq = dequeue & head_valid_q & ~clr;
    // Level counts the head register too, so the RAM holds level - head_valid.
    ram_cnt = level_q - LW'(head_valid_q);
    // Refill the head whenever it is (or is about to become) empty and the RAM
    // has data; an entry written this edge is not yet readable, so it waits.
    refill  = (~head_valid_q | acc_deq) & (ram_cnt != '0) & ~clr;

    level_d      = level_q + LW'(acc_enq) - LW'(acc_deq);
    waddr_d      = waddr_q + SIZE_SCALE'(acc_enq);
    raddr_d      = raddr_q + SIZE_SCALE'(refill);
    head_valid_d = head_valid_q;
    rdata_d      = rdata_q;
    ovf_d        = ovf_q | (enqueue & full_q);
    udf_d        = udf_q | (dequeue & ~head_valid_q);

    if (refill) begin
      head_valid_d = 1'b1;
      rdata_d      = mem_q[raddr_q];
    end else if (acc_deq) begin
      head_valid_d = 1'b0;
    end

    // Flush keeps rdata as it was; only bookkeeping is cleared.
    if (clr) begin
      level_d      = '0;
      waddr_d      = '0;
      raddr_d      = '0;
      head_valid_d = 1'b0;
      ovf_d        = 1'b0;
      udf_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_enq) mem_q[waddr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q      <= '0;
      raddr_q      <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      rdata_q      <= '0;
      full_q       <= 1'b0;
      filled_q     <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      rdata_q      <= rdata_d;
      full_q       <= (level_d == DEPTH_L);
      filled_q     <= (level_d > THRESH_L);
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [LW-1:0] max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                max_q <= '0;
    else if (clr)              max_q <= '0;
    else if (level_d > max_q)  max_q <= level_d;
  end

  assign max_level = max_q;
`else
  assign max_level = '0;
`endif

  assign full      = full_q;
  assign filled    = filled_q;
  assign level     = level_q;
  assign empty     = ~head_valid_q;
  assign rdata     = rdata_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

  localparam int SS    = 4;
  localparam int W     = 8;
  localparam int TH    = 8;
  localparam int DEPTH = 16;
`ifdef SYNC_FIFO_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         enqueue = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         dequeue = 1'b0;
  logic         full, empty, filled, overflow, underflow;
  logic [W-1:0] rdata;
  logic [SS:0]  level, max_level;

  sync_fifo_fwft #(.SIZE_SCALE(SS), .WIDTH(W), .FILLED_THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .enqueue(enqueue), .wdata(wdata), .full(full),
    .dequeue(dequeue), .rdata(rdata), .empty(empty),
    .filled(filled), .level(level),
    .overflow(overflow), .underflow(underflow), .max_level(max_level)
  );

  always #5 clk = ~clk;

  // Reference model: queue of entries stamped with the edge that accepted
  // them. An entry can be presented at the head only from the edge after the
  // one that wrote it.
  typedef struct {
    logic [W-1:0] d;
    int           e;
  } ent_t;

  ent_t mq[$];
  int   edge_n = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   m_ovf = 1'b0;
  bit   m_udf = 1'b0;
  int   m_max = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_vis();
    return (mq.size() > 0) && (mq[0].e <= edge_n - 1);
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".empty"},     32'(empty),     32'(!m_vis()));
    chk({ph, ".level"},     32'(level),     32'(mq.size()));
    chk({ph, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    chk({ph, ".filled"},    32'(filled),    32'(mq.size() > TH));
    chk({ph, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({ph, ".underflow"}, 32'(underflow), 32'(m_udf));
    chk({ph, ".max_level"}, 32'(max_level), WM ? 32'(m_max) : 32'd0);
    if (m_vis()) chk({ph, ".rdata"}, 32'(rdata), 32'(mq[0].d));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_max = 0;
  endtask

  task automatic check_reset(input string ph);
    check_all(ph);
    chk({ph, ".rdata0"}, 32'(rdata), 32'd0);
  endtask

  task automatic step(input bit e, input logic [W-1:0] d, input bit q, input bit c,
                      input string ph);
    bit emp, fl;
    enqueue = e;
    wdata   = d;
    dequeue = q;
    clr     = c;
    emp = !m_vis();
    fl  = (mq.size() == DEPTH);
    @(posedge clk);
    edge_n++;
    if (c) begin
      model_reset();
    end else begin
      if (q && emp) m_udf = 1'b1;
      if (e && fl)  m_ovf = 1'b1;
      if (q && !emp) void'(mq.pop_front());
      if (e && !fl)  mq.push_back('{d, edge_n});
      if (mq.size() > m_max) m_max = mq.size();
    end
    #1;
    enqueue = 1'b0;
    dequeue = 1'b0;
    clr     = 1'b0;
    check_all(ph);
  endtask

  initial begin
    #2;
    model_reset();
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0, "fill");
    chk("fill.full16", 32'(full), 32'd1);
    chk("fill.level16", 32'(level), 32'd16);
    step(1'b1, 8'h77, 1'b0, 1'b0, "ovf");
    chk("ovf.flag", 32'(overflow), 32'd1);

    // Drain in order, then underflow; flags hold until clr
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain.order", 32'(rdata), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0, "drain");
    end
    chk("drain.empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "udf");
    chk("udf.flag", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, "hold");
    step(1'b0, '0, 1'b0, 1'b1, "clr1");

    // Fall-through latency
    step(1'b1, 8'hA5, 1'b0, 1'b0, "ft0");
    chk("ft0.empty", 32'(empty), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, "ft1");
    chk("ft1.rdata", 32'(rdata), 32'hA5);
    step(1'b0, '0, 1'b1, 1'b0, "ft2");
    chk("ft2.empty", 32'(empty), 32'd1);

    // Level 5, simultaneous ops across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, "lv5");
    step(1'b0, '0, 1'b0, 1'b0, "lv5i");
    for (int i = 0; i < 100; i++) step(1'b1, W'($urandom), 1'b1, 1'b0, "sim");
    chk("sim.level5", 32'(level), 32'd5);

    // Simultaneous ops while full
    while (mq.size() < DEPTH) step(1'b1, W'($urandom), 1'b0, 1'b0, "tofull");
    step(1'b1, W'($urandom), 1'b1, 1'b0, "fullsim");
    chk("fullsim.level15", 32'(level), 32'd15);
    chk("fullsim.ovf", 32'(overflow), 32'd1);

    // Threshold and flush with enqueue
    step(1'b0, '0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 12; i++) begin
      step(1'b1, W'($urandom), 1'b0, 1'b0, "thr");
      if (i == 7) chk("thr.at8", 32'(filled), 32'd0);
      if (i == 8) chk("thr.at9", 32'(filled), 32'd1);
    end
    step(1'b1, W'($urandom), 1'b0, 1'b1, "clr12");
    chk("clr12.level", 32'(level), 32'd0);
    chk("clr12.empty", 32'(empty), 32'd1);

    // Watermark ramp 11, drain to 3
    for (int i = 0; i < 11; i++) step(1'b1, W'($urandom), 1'b0, 1'b0, "wm_up");
    step(1'b0, '0, 1'b0, 1'b0, "wm_i");
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, "wm_dn");
    chk("wm.level3", 32'(level), 32'd3);
    chk("wm.max11", 32'(max_level), WM ? 32'd11 : 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 79) == 0), "rnd");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0, "pre");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, "post0");
    step(1'b0, '0, 1'b0, 1'b0, "post1");
    chk("post1.rdata", 32'(rdata), 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock, first-word-fall-through FIFO on block RAM, parametrised in depth and width; next generation of the team's FIFO family.
- Provides an exact occupancy count, a programmable "filled" threshold, synchronous flush, and sticky overflow/underflow error flags. Misuse is recorded in these flags and does not stop simulation.
- Sits between capture/packing stages that share one clock domain, e.g. the pixel packer feeding the DDR write path.

Parameters:
- SIZE_SCALE, 10, log2 of capacity; capacity = 2**SIZE_SCALE entries (all slots usable).
- WIDTH, 8, data width in bits.
- FILLED_THRESH, 512, `filled` asserts when level > FILLED_THRESH; legal range 0..2**SIZE_SCALE-1.

Ports:
- clk, input, 1, sole clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous flush.
- enqueue, input, 1, write request.
- wdata, input, WIDTH, write data.
- full, output, 1, level == 2**SIZE_SCALE.
- dequeue, input, 1, pop head entry.
- rdata, output, WIDTH, head entry; valid whenever empty==0.
- empty, output, 1, no head entry presented.
- filled, output, 1, level > FILLED_THRESH.
- level, output, SIZE_SCALE+1, entries accepted and not yet dequeued.
- overflow, output, 1, sticky: enqueue attempted while full.
- underflow, output, 1, sticky: dequeue attempted while empty.
- max_level, output, SIZE_SCALE+1, peak-level watermark (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): empty=1, full=0, filled=0, level=0, overflow=0, underflow=0, max_level=0, rdata=0, pointers=0. RAM contents are not cleared.
- Storage: RAM with synchronous read plus a head output register.
  - RAM entries + head register ≤ 2**SIZE_SCALE at all times.
  - empty = ~head_valid.
- Enqueue is accepted iff enqueue && !full (full as registered before the edge).
  - Accepted write goes to RAM[waddr]; waddr wraps modulo 2**SIZE_SCALE.
- Dequeue is accepted iff dequeue && !empty.
- Level update: level_next = level + acc_enq - acc_deq, computed in SIZE_SCALE+1 bits. full, filled and level are registered from level_next.
- Fall-through latency: an enqueue accepted at edge k into an empty FIFO gives empty=0 and valid rdata after edge k+1.
- Head refill: whenever the head is empty or being dequeued, and the RAM holds ≥1 entry, the RAM read is issued and the head loads at that same edge.
  - Back-to-back dequeue sustains 1 entry/cycle with no bubble while RAM holds data.
- Simultaneous enqueue+dequeue:
  - not full, not empty: level unchanged, both accepted.
  - full: dequeue accepted, enqueue rejected, overflow set; full drops after that edge.
  - empty: enqueue accepted, dequeue ignored, underflow set; the head fills after edge k+1 per the latency rule.
- Wrap-around: pointers wrap without affecting data; level alone distinguishes full from empty.
- Sticky flags: overflow and underflow stay set until rst_n or clr. The rejected operation has no other effect.
- clr: highest priority; enqueue/dequeue in the same cycle are ignored.
  - After that edge: empty=1, full=0, filled=0, level=0, overflow=0, underflow=0, max_level=0, pointers=0, rdata holds its last value.
- Reset mid-operation: all in-flight data is discarded; outputs return to reset values asynchronously.

Optional Feature:
- Macro SYNC_FIFO_WATERMARK_EN.
- Defined: max_level registers max(max_level, level_next) every cycle; cleared by rst_n or clr.
- Undefined: max_level is tied to 0 and no watermark logic is built.

Test Plan:
- Fill/drain: SIZE_SCALE=4, WIDTH=8. Enqueue 0x00..0x0F on consecutive cycles → full=1 after 16th edge, level=16. Dequeue 16 consecutive cycles → rdata 0x00..0x0F in order, empty=1, level=0.
- Fall-through: single enqueue of 0xA5 at edge k into an empty FIFO → empty=0 and rdata=0xA5 after edge k+1; dequeue → empty=1 after next edge.
- Error flags: enqueue 0x77 while full → overflow=1, level stays 16, 0x77 never read. Dequeue while empty → underflow=1, level stays 0. Both flags hold until clr.
- Simultaneous ops: at level=5, enqueue+dequeue for 100 cycles → level stays 5, output order preserved across pointer wrap. With full, enqueue+dequeue → level 15, overflow=1.
- Threshold and flush: FILLED_THRESH=8. Level 8→9 → filled rises after that edge. clr at level 12 with enqueue=1 → level=0, empty=1, flags 0.
- Watermark (macro defined): ramp to level 11, drain to 3 → max_level=11. Assert rst_n=0 mid-stream → all outputs return to reset values immediately, without waiting for a clock edge.
